bg_tile_rom: RTL and testbench

BG_TILE_ROM -- requirements
Module: bg_tile_rom

---
 rtl/bg_tile_rom.sv | 74 +++++++
 tb/tb_bg_tile_rom.sv | 135 +++++++++++++
 2 files changed

// File: rtl/bg_tile_rom.sv
// Procedural background sprite sheet: 32x32 tiles addressed by sheet (x, y), RGB444 out.
// One-cycle registered lookup, a new address every cycle, no stall; video_on=0 blanks to black.
module bg_tile_rom #(
  parameter int unsigned SHEET_W   = 256,
  parameter int unsigned SHEET_H   = 128,
  parameter logic [11:0] KEY_COLOR = 12'h00F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic [11:0] color
);

  logic [2:0]  tile_c;
  logic [1:0]  tile_r;
  logic [4:0]  u;
  logic [4:0]  v;
  logic [5:0]  uv_sum;
  logic        in_sheet;
  logic [11:0] pixel;

  assign tile_c = x[7:5];
  assign tile_r = y[6:5];
  assign u      = x[4:0];
  assign v      = y[4:0];
  assign uv_sum = {1'b0, u} + {1'b0, v};

  // Full-width compare so addresses past the sheet never alias onto a tile.
  assign in_sheet = ({22'd0, x} < SHEET_W) && ({22'd0, y} < SHEET_H);

  always_comb begin
    pixel = KEY_COLOR;
    if (in_sheet) begin
      if (tile_r == 2'd2) begin
        case (tile_c)
          3'd0: begin
            // Brick wall: mortar rows every 8 lines, vertical joints offset per course.
            if (v[2:0] == 3'd7)
              pixel = 12'h888;
            else if (u[3:0] == (v[3] ? 4'd7 : 4'd15))
              pixel = 12'h888;
            else
              pixel = 12'hB42;
          end
          3'd1: begin
            if (u == 5'd0 || v == 5'd0)
              pixel = 12'hFFF;
            else if (u == 5'd31 || v == 5'd31)
              pixel = 12'h555;
            else
              pixel = 12'hAAA;
          end
          3'd2:    pixel = (uv_sum[2:0] == 3'd0) ? 12'h4AF : 12'h05C;
          3'd3:    pixel = (u[1] ^ v[1]) ? 12'h0A0 : 12'h070;
          default: pixel = KEY_COLOR;
        endcase
      end else if (tile_r == 2'd1 && tile_c == 3'd7) begin
        pixel = (u[2:0] == v[2:0]) ? 12'h444 : 12'h333;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      color <= 12'h000;
    else if (!video_on)
      color <= 12'h000;
    else
      color <= pixel;
  end

endmodule

// File: tb/tb_bg_tile_rom.sv
// Directed bench for bg_tile_rom: vector table plus reset, blanking and streaming sequences.
module tb_bg_tile_rom;

  logic        clk;
  logic        rst_n;
  logic        video_on;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [11:0] color;

  int errors = 0;
  int checks = 0;

  bg_tile_rom dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .video_on (video_on),
    .x        (x),
    .y        (y),
    .color    (color)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vo;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [11:0] exp);
    checks++;
    if (color !== exp) begin
      errors++;
      $display("FAIL %s: color=%h expected=%h", name, color, exp);
    end
  endtask

  task automatic drive(input logic vo, input logic [9:0] xi, input logic [9:0] yi);
    @(negedge clk);
    video_on = vo;
    x        = xi;
    y        = yi;
  endtask

  task automatic edge_then_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 10'd3,   10'd71,  12'h888};
    vecs[1]  = '{1'b1, 10'd15,  10'd66,  12'h888};
    vecs[2]  = '{1'b1, 10'd7,   10'd74,  12'h888};
    vecs[3]  = '{1'b1, 10'd3,   10'd66,  12'hB42};
    vecs[4]  = '{1'b1, 10'd229, 10'd35,  12'h333};
    vecs[5]  = '{1'b1, 10'd226, 10'd34,  12'h444};
    vecs[6]  = '{1'b1, 10'd32,  10'd64,  12'hFFF};
    vecs[7]  = '{1'b1, 10'd96,  10'd66,  12'h0A0};
    vecs[8]  = '{1'b1, 10'd40,  10'd5,   12'h00F};
    vecs[9]  = '{1'b1, 10'd300, 10'd10,  12'h00F};
    vecs[10] = '{1'b1, 10'd10,  10'd200, 12'h00F};
    vecs[11] = '{1'b1, 10'd64,  10'd64,  12'h4AF};  // water u=0 v=0
    vecs[12] = '{1'b1, 10'd65,  10'd64,  12'h05C};
    vecs[13] = '{1'b1, 10'd95,  10'd65,  12'h4AF};  // u+v = 32
    vecs[14] = '{1'b1, 10'd63,  10'd70,  12'h555};  // steel u=31
    vecs[15] = '{1'b1, 10'd40,  10'd70,  12'hAAA};
    vecs[16] = '{1'b1, 10'd96,  10'd64,  12'h070};
    vecs[17] = '{1'b0, 10'd3,   10'd66,  12'h000};

    // Reset held two edges with live inputs, then released.
    rst_n = 1'b0; video_on = 1'b1; x = 10'd3; y = 10'd66;
    edge_then_sample();
    check("reset_edge1", 12'h000);
    edge_then_sample();
    check("reset_edge2", 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    edge_then_sample();
    check("reset_release", 12'hB42);

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].vo, vecs[i].x, vecs[i].y);
      edge_then_sample();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Blank then unblank at the same address.
    drive(1'b0, 10'd3, 10'd66);
    edge_then_sample();
    check("blank", 12'h000);
    drive(1'b1, 10'd3, 10'd66);
    edge_then_sample();
    check("unblank", 12'hB42);

    // Output holds between edges while the address changes.
    drive(1'b1, 10'd32, 10'd64);
    #2;
    check("hold_between_edges", 12'hB42);
    edge_then_sample();
    check("hold_then_update", 12'hFFF);

    // Mid-stream reset: no stale pixel afterwards.
    drive(1'b1, 10'd3, 10'd71);
    edge_then_sample();
    check("pre_reset", 12'h888);
    @(negedge clk);
    rst_n = 1'b0;
    edge_then_sample();
    check("midstream_reset", 12'h000);
    @(negedge clk);
    x = 10'd226; y = 10'd34;
    edge_then_sample();
    check("reset_priority", 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    edge_then_sample();
    check("post_reset", 12'h444);

    // Back-to-back road row, one pixel per cycle; v = 1 at y=33.
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 10'(224 + i), 10'd33);
      edge_then_sample();
      check($sformatf("stream_x%0d", 224 + i), ((i % 8) == 1) ? 12'h444 : 12'h333);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
